// File: rtl/dma_page_addr.sv
// dma_page_addr: DMA page-address companion for an 8237-style DMA controller.
// Builds the system memory address {page[chan], A15..A8, A7..A0} during DMA
// cycles and flags multi-DACK faults and 64K address wrap.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   cs_page          page/status register select (active low)
//   ior, iow         CPU I/O read / write strobes (active low)
//   a[2:0]           register select: 0->ch0 1->ch2 2->ch3 3->ch1 4->status
//   db_in[7:0]       CPU write data; A15..A8 from the 8237 while adstb=1
//   db_out, db_oe    register read data and its drive enable
//   aen              DMA owns the bus (blocks CPU register access)
//   adstb            8237 address strobe, latches A15..A8 from db_in
//   dack[NUM_CH-1:0] DMA acknowledge, expected one-hot
//   a_lo[7:0]        A7..A0 straight from the 8237
//   addr, addr_oe    composed DMA address and its drive enable
//   irq_err          OR of the sticky status bits
module dma_page_addr #(
  parameter int unsigned PAGE_BITS = 4,
  parameter int unsigned NUM_CH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_page,
  input  logic                   ior,
  input  logic                   iow,
  input  logic [2:0]             a,
  input  logic [7:0]             db_in,
  output logic [7:0]             db_out,
  output logic                   db_oe,
  input  logic                   aen,
  input  logic                   adstb,
  input  logic [NUM_CH-1:0]      dack,
  input  logic [7:0]             a_lo,
  output logic [PAGE_BITS+15:0]  addr,
  output logic                   addr_oe,
  output logic                   irq_err
);

  localparam int unsigned CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNTW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PAGE_BITS-1:0]   page_q [NUM_CH];
  logic [7:0]             a_hi_q;
  logic [CHW-1:0]         chan_q, chan_d;
  logic [PAGE_BITS+15:0]  addr_q, addr_d;
  logic                   addr_oe_q, addr_oe_d;
  logic                   multi_q, multi_d, wrap_q, wrap_d;
  logic                   irq_q;
  logic [7:0]             db_out_q;
  logic                   db_oe_q;
  logic                   wr_cond_q, stat_rd_q;
  logic [15:0]            prev_ad_q;
  logic                   prev_xfer_q;

  logic                   wr_cond, rd_cond, wr_pulse;
  logic                   stat_rd, stat_clr;
  logic                   sel_page;
  logic [CHW-1:0]         sel;
  logic [7:0]             rd_data;
  logic [CNTW-1:0]        dack_cnt;
  logic [CHW-1:0]         dack_idx;
  logic                   multi_set, wrap_set;
  logic [15:0]            cur_ad;

  // CPU access is only honoured while the DMA controller does not own the bus.
  assign wr_cond  = ~cs_page & ~iow & ior & ~aen;
  assign rd_cond  = ~cs_page & ~ior & iow & ~aen;
  assign wr_pulse = wr_cond & ~wr_cond_q;

  // Status clears once a status read ends (ior released while a=4).
  assign stat_rd  = rd_cond & (a == 3'd4);
  assign stat_clr = stat_rd_q & ~stat_rd;

  // PC port order: 0x81=ch2, 0x82=ch3, 0x83=ch1, 0x87=ch0 folded onto a[2:0].
  always_comb begin
    sel      = '0;
    sel_page = 1'b1;
    case (a)
      3'd0:    sel = CHW'(0);
      3'd1:    sel = CHW'(2);
      3'd2:    sel = CHW'(3);
      3'd3:    sel = CHW'(1);
      default: sel_page = 1'b0;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (sel_page) begin
      rd_data[PAGE_BITS-1:0] = page_q[sel];
    end else if (a == 3'd4) begin
      rd_data = {6'b0, wrap_q, multi_q};
    end
  end

  always_comb begin
    dack_cnt = '0;
    dack_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (dack[i]) begin
        dack_cnt = dack_cnt + CNTW'(1);
        dack_idx = CHW'(i);
      end
    end
  end

  assign cur_ad   = {a_hi_q, a_lo};
  assign wrap_set = (state_q == XFER) && prev_xfer_q &&
                    (prev_ad_q == 16'hFFFF) && (cur_ad == 16'h0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    addr_d    = addr_q;
    addr_oe_d = 1'b0;
    multi_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (aen) state_d = GRANT;
      end
      GRANT: begin
        if (!aen) begin
          state_d = IDLE;
        end else if (dack_cnt == CNTW'(1)) begin
          chan_d  = dack_idx;
          state_d = XFER;
        end else if (dack_cnt > CNTW'(1)) begin
          multi_set = 1'b1;
        end
      end
      XFER: begin
        if (!aen) begin
          state_d = IDLE;
        end else if (dack_cnt > CNTW'(1)) begin
          multi_set = 1'b1;
          state_d   = GRANT;
        end else if (dack_cnt == '0) begin
          state_d = GRANT;
        end else begin
          // Use the live single DACK so a channel switch takes effect at once.
          chan_d    = dack_idx;
          addr_d    = {page_q[dack_idx], a_hi_q, a_lo};
          addr_oe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    multi_d = multi_q;
    wrap_d  = wrap_q;
    if (stat_clr) begin
      multi_d = 1'b0;
      wrap_d  = 1'b0;
    end
    // A fault arriving in the clearing cycle must not be lost.
    if (multi_set) multi_d = 1'b1;
    if (wrap_set)  wrap_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        page_q[i] <= '0;
      end
      a_hi_q      <= '0;
      chan_q      <= '0;
      addr_q      <= '0;
      addr_oe_q   <= 1'b0;
      multi_q     <= 1'b0;
      wrap_q      <= 1'b0;
      irq_q       <= 1'b0;
      db_out_q    <= '0;
      db_oe_q     <= 1'b0;
      wr_cond_q   <= 1'b0;
      stat_rd_q   <= 1'b0;
      prev_ad_q   <= '0;
      prev_xfer_q <= 1'b0;
    end else begin
      if (wr_pulse && sel_page) begin
        page_q[sel] <= db_in[PAGE_BITS-1:0];
      end
      if (adstb) begin
        a_hi_q <= db_in;
      end
      chan_q      <= chan_d;
      addr_q      <= addr_d;
      addr_oe_q   <= addr_oe_d;
      multi_q     <= multi_d;
      wrap_q      <= wrap_d;
      irq_q       <= multi_d | wrap_d;
      db_oe_q     <= rd_cond;
      db_out_q    <= rd_cond ? rd_data : '0;
      wr_cond_q   <= wr_cond;
      stat_rd_q   <= stat_rd;
      prev_ad_q   <= cur_ad;
      prev_xfer_q <= (state_q == XFER);
    end
  end

  assign addr    = addr_q;
  assign addr_oe = addr_oe_q;
  assign db_out  = db_out_q;
  assign db_oe   = db_oe_q;
  assign irq_err = irq_q;

endmodule

// File: doc/dma_page_addr.md
Name: dma_page_addr

Overview:
- Downstream companion of intel8237A in the IBM PC system board. It builds the 20-bit system memory address during DMA cycles.
- Address composition:
  - Page nibble: from a per-channel page register file (PC ports 0x80–0x87 equivalent).
  - Middle byte: A15–A8, latched from the 8237 data bus on ADSTB.
  - Low byte: A7–A0, taken directly from the 8237.
- Flags multi-DACK faults and 64K page wrap. The CPU can read and clear these flags.

Parameters:
- PAGE_BITS, 4, width of each page register (drives address bits 19:16).
- NUM_CH, 4, number of DMA channels and page registers (fixed at 4; dack is one-hot over NUM_CH).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- cs_page  input  1  page/status register select, active low.
- ior  input  1  I/O read strobe, active low.
- iow  input  1  I/O write strobe, active low.
- a  input  3  register select: 0→ch0, 1→ch2, 2→ch3, 3→ch1, 4→status; 5–7 reserved.
- db_in  input  8  data bus in (CPU write data; 8237 A15–A8 during adstb).
- db_out  output  8  register read data.
- db_oe  output  1  db_out drive enable.
- aen  input  1  address enable from 8237 (DMA owns bus).
- adstb  input  1  address strobe from 8237, active high.
- dack  input  NUM_CH  DMA acknowledge from 8237, active high.
- a_lo  input  8  A7–A0 from 8237.
- addr  output  20  composed DMA memory address.
- addr_oe  output  1  addr drive enable.
- irq_err  output  1  OR of sticky status bits.

Behaviour:
- Reset values:
  - Outputs: addr=0, addr_oe=0, db_out=0, db_oe=0, irq_err=0.
  - Internal: all page regs=0, a_hi=0, chan=0, status=0, state=IDLE.
- CPU write:
  - Condition: cs_page=0, iow=0, ior=1, aen=0.
  - Action: page[sel] <= db_in[PAGE_BITS-1:0]. Upper bits of db_in are ignored.
  - Edge-detected: exactly one write per strobe assertion, even if iow is held low for many cycles.
  - Writes with a≥4 are ignored.
- CPU read:
  - Condition: cs_page=0, ior=0, iow=1, aen=0.
  - Timing: db_oe=1 and db_out valid on the next posedge after the condition is seen; both hold until the condition drops, then db_oe=0 on the next posedge.
  - Page read: db_out = {0000, page[sel]}.
  - Status read: db_out = {000000, wrap, multi}. Status clears on the cycle after the read strobe rises (rising edge of ior while a=4).
  - Reserved a: db_out=0.
- aen=1 blocks all CPU register access; strobes are ignored and not queued.
- ADSTB latch: while adstb=1 at a posedge, a_hi <= db_in. The last sampled value holds after adstb falls.
- State machine:
  - IDLE:
    - aen=1 → GRANT.
  - GRANT (aen=1, no dack yet):
    - Exactly one dack bit set → capture chan = index, go to XFER.
    - More than one dack bit set → multi<=1, stay in GRANT.
    - aen=0 → IDLE.
  - XFER:
    - addr = {page[chan], a_hi, a_lo}; addr_oe=1. Both registered: valid one cycle after entry, updated every cycle.
    - dack changes to a different single channel → re-capture chan.
    - More than one dack bit set → multi<=1, addr_oe<=0, go to GRANT.
    - dack all zero with aen=1 → GRANT, addr_oe<=0.
    - aen=0 → IDLE, addr_oe<=0.
- Wrap detect (in XFER only): if the previous {a_hi,a_lo}=16'hFFFF and the current value=16'h0000, then wrap<=1. The page is NOT incremented; the hardware wraps within 64K.
- irq_err = multi | wrap, registered.
- Page registers are unaffected by DMA activity.
- Reset mid-transfer: immediate return to reset values, addr_oe=0 asynchronously.

Test Plan:
- Reset, then CPU write iow=0 for 3 cycles, a=1, db_in=8'h0A → page[ch2]=A. Read back a=1 → db_out=8'h0A, db_oe=1 one cycle after ior=0; only one write is registered.
- aen=1, iow=0, a=0, db_in=5 → page[ch0] stays 0; a subsequent read with aen=0 returns 8'h00.
- page[ch0]=3, aen=1, adstb pulse with db_in=8'h12, dack=0001, a_lo=8'h34 → addr=20'h31234, addr_oe=1 the cycle after XFER entry.
- In XFER, {a_hi,a_lo} steps 16'hFFFF→16'h0000 → addr=20'h30000, wrap=1, irq_err=1. Status read returns 8'h02; the next status read returns 8'h00.
- dack=0011 during GRANT → multi=1, addr_oe stays 0, irq_err=1.
- Assert reset during XFER → addr_oe=0 immediately, all page regs read 0 afterwards.
